// File: rtl/nested_counter3.sv
// nested_counter3: three-level nested loop counter (x inner, y middle, z outer)
// that produces feature-map addresses for the conv/pool engines.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   i_start               start pulse, accepted only while idle
//   i_abort               return to idle without a done pulse
//   i_mode_cont           sampled at start: 0 one-shot, 1 continuous
//   ce                    advance enable
//   i_x/y/z_last          last value per dimension, sampled at start
//   o_x, o_y, o_z         current counts
//   o_busy                high while running
//   o_x_wrap, o_y_wrap    combinational wrap strobes for x and y
//   o_last                combinational: all dimensions at their last value
//   o_done                one-cycle pulse after the final step of a sweep
//   o_done_sticky         set with o_done, cleared by rst or an accepted start
module nested_counter3 #(
    parameter int unsigned CNT_WIDTH = 5,
    parameter bit          Z_EN      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic                 i_mode_cont,
    input  logic                 ce,
    input  logic [CNT_WIDTH-1:0] i_x_last,
    input  logic [CNT_WIDTH-1:0] i_y_last,
    input  logic [CNT_WIDTH-1:0] i_z_last,
    output logic [CNT_WIDTH-1:0] o_x,
    output logic [CNT_WIDTH-1:0] o_y,
    output logic [CNT_WIDTH-1:0] o_z,
    output logic                 o_busy,
    output logic                 o_x_wrap,
    output logic                 o_y_wrap,
    output logic                 o_last,
    output logic                 o_done,
    output logic                 o_done_sticky
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   x_q, x_d;
    logic [CNT_WIDTH-1:0]   y_q, y_d;
    logic [CNT_WIDTH-1:0]   z_q, z_d;
    logic [CNT_WIDTH-1:0]   x_last_q, x_last_d;
    logic [CNT_WIDTH-1:0]   y_last_q, y_last_d;
    logic [CNT_WIDTH-1:0]   z_last_q, z_last_d;
    logic                   mode_q, mode_d;
    logic                   done_q, done_d;
    logic                   sticky_q, sticky_d;

    logic busy;
    logic x_at_last;
    logic y_at_last;
    logic z_at_last;

    assign busy      = (state_q == StRun);
    assign x_at_last = (x_q == x_last_q);
    assign y_at_last = (y_q == y_last_q);
    // With z disabled the outer loop always counts as being on its last value.
    assign z_at_last = Z_EN ? (z_q == z_last_q) : 1'b1;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        x_last_d = x_last_q;
        y_last_d = y_last_q;
        z_last_d = z_last_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        sticky_d = sticky_q;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    x_last_d = i_x_last;
                    y_last_d = i_y_last;
                    z_last_d = Z_EN ? i_z_last : '0;
                    mode_d   = i_mode_cont;
                    x_d      = '0;
                    y_d      = '0;
                    z_d      = '0;
                    sticky_d = 1'b0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (i_abort) begin
                    // Abort beats a coincident final step: no done, sticky untouched.
                    x_d     = '0;
                    y_d     = '0;
                    z_d     = '0;
                    state_d = StIdle;
                end else if (ce) begin
                    if (!x_at_last) begin
                        x_d = x_q + CNT_WIDTH'(1);
                    end else begin
                        x_d = '0;
                        if (!y_at_last) begin
                            y_d = y_q + CNT_WIDTH'(1);
                        end else begin
                            y_d = '0;
                            if (!z_at_last) begin
                                z_d = z_q + CNT_WIDTH'(1);
                            end else begin
                                z_d      = '0;
                                done_d   = 1'b1;
                                sticky_d = 1'b1;
                                if (!mode_q) begin
                                    state_d = StIdle;
                                end
                            end
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (!Z_EN) begin
            z_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            x_last_q <= '0;
            y_last_q <= '0;
            z_last_q <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            x_last_q <= x_last_d;
            y_last_q <= y_last_d;
            z_last_q <= z_last_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
            sticky_q <= sticky_d;
        end
    end

    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_z           = z_q;
    assign o_busy        = busy;
    assign o_x_wrap      = busy & ce & x_at_last;
    assign o_y_wrap      = busy & ce & x_at_last & y_at_last;
    assign o_last        = busy & x_at_last & y_at_last & z_at_last;
    assign o_done        = done_q;
    assign o_done_sticky = sticky_q;

endmodule

// File: tb/tb_nested_counter3.sv
// Self-checking bench for nested_counter3. The reference model tracks a single
// linear step index n per sweep and derives x/y/z from it by division/modulo.
module tb_nested_counter3;

    localparam int unsigned W = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_start = 1'b0;
    logic         i_abort = 1'b0;
    logic         i_mode_cont = 1'b0;
    logic         ce = 1'b0;
    logic [W-1:0] i_x_last = '0;
    logic [W-1:0] i_y_last = '0;
    logic [W-1:0] i_z_last = '0;

    logic [W-1:0] o_x, o_y, o_z;
    logic         o_busy, o_x_wrap, o_y_wrap, o_last, o_done, o_done_sticky;
    logic [W-1:0] o_x2, o_y2, o_z2;
    logic         o_busy2, o_x_wrap2, o_y_wrap2, o_last2, o_done2, o_done_sticky2;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit m_busy = 0;
    int m_n = 0;
    int m_xl = 0, m_yl = 0, m_zl = 0;
    bit m_cont = 0;
    bit m_done = 0;
    bit m_sticky = 0;

    always #5 clk = ~clk;

    nested_counter3 #(.CNT_WIDTH(W), .Z_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
        .i_mode_cont(i_mode_cont), .ce(ce),
        .i_x_last(i_x_last), .i_y_last(i_y_last), .i_z_last(i_z_last),
        .o_x(o_x), .o_y(o_y), .o_z(o_z), .o_busy(o_busy),
        .o_x_wrap(o_x_wrap), .o_y_wrap(o_y_wrap), .o_last(o_last),
        .o_done(o_done), .o_done_sticky(o_done_sticky)
    );

    nested_counter3 #(.CNT_WIDTH(W), .Z_EN(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
        .i_mode_cont(i_mode_cont), .ce(ce),
        .i_x_last(i_x_last), .i_y_last(i_y_last), .i_z_last(i_z_last),
        .o_x(o_x2), .o_y(o_y2), .o_z(o_z2), .o_busy(o_busy2),
        .o_x_wrap(o_x_wrap2), .o_y_wrap(o_y_wrap2), .o_last(o_last2),
        .o_done(o_done2), .o_done_sticky(o_done_sticky2)
    );

    function automatic logic [20:0] exp_vec();
        int ex, ey, ez;
        logic xw, yw, lst;
        ex  = m_n % (m_xl + 1);
        ey  = (m_n / (m_xl + 1)) % (m_yl + 1);
        ez  = m_n / ((m_xl + 1) * (m_yl + 1));
        xw  = m_busy && ce && (ex == m_xl);
        yw  = xw && (ey == m_yl);
        lst = m_busy && (ex == m_xl) && (ey == m_yl) && (ez == m_zl);
        return {5'(ex), 5'(ey), 5'(ez), m_busy, m_done, m_sticky, xw, yw, lst};
    endfunction

    function automatic logic [20:0] got_vec();
        return {o_x, o_y, o_z, o_busy, o_done, o_done_sticky, o_x_wrap, o_y_wrap, o_last};
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void model_step();
        int total;
        if (rst) begin
            m_busy = 0; m_n = 0; m_xl = 0; m_yl = 0; m_zl = 0;
            m_cont = 0; m_done = 0; m_sticky = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (i_start) begin
                    m_xl = int'(i_x_last); m_yl = int'(i_y_last); m_zl = int'(i_z_last);
                    m_cont = i_mode_cont; m_n = 0; m_sticky = 0; m_busy = 1;
                end
            end else if (i_abort) begin
                m_busy = 0; m_n = 0;
            end else if (ce) begin
                total = (m_xl + 1) * (m_yl + 1) * (m_zl + 1);
                if (m_n == total - 1) begin
                    m_n = 0; m_done = 1; m_sticky = 1;
                    if (!m_cont) m_busy = 0;
                end else begin
                    m_n++;
                end
            end
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; ce = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic start_run(input int xl, input int yl, input int zl, input bit cont);
        i_x_last = W'(xl); i_y_last = W'(yl); i_z_last = W'(zl);
        i_mode_cont = cont; i_start = 1'b1; i_abort = 1'b0; ce = 1'b0;
        tick();
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (got_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_init got=%h exp=%h", got_vec(), exp_vec());
        end
        start_run(5, 1, 1, 0);
        ce = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        #1;
        checks++;
        if (o_x !== 5'd3) begin
            errors++; $display("FAIL reset_pre_x got=%0d exp=3", o_x);
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (got_vec() !== exp_vec() || {o_x, o_busy, o_done, o_done_sticky} !== '0) begin
            errors++; $display("FAIL reset_mid got=%h exp=%h", got_vec(), exp_vec());
        end
        ce = 1'b0;
    endtask

    task automatic test_oneshot_sweep();
        int xw_cnt = 0, yw_cnt = 0, done_at = 0;
        do_reset();
        start_run(2, 1, 1, 0);
        ce = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            #1;
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL sweep k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
            if (o_x_wrap) xw_cnt++;
            if (o_y_wrap) yw_cnt++;
            tick();
            if (o_done && done_at == 0) done_at = k;
        end
        checks++;
        if (done_at != 12 || xw_cnt != 4 || yw_cnt != 2) begin
            errors++;
            $display("FAIL sweep_counts got done_at=%0d xw=%0d yw=%0d exp 12/4/2",
                     done_at, xw_cnt, yw_cnt);
        end
        ce = 1'b0;
    endtask

    task automatic test_gapped_ce();
        bit pat [5] = '{1, 0, 0, 1, 0};
        int dones = 0;
        do_reset();
        start_run(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            ce = pat[k];
            #1;
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL gapped k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
            tick();
            if (o_done) dones++;
        end
        checks++;
        if (dones != 1) begin
            errors++; $display("FAIL gapped_dones got=%0d exp=1", dones);
        end
        ce = 1'b0;
    endtask

    task automatic test_continuous();
        int done_k[$];
        do_reset();
        start_run(3, 0, 0, 1);
        ce = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            #1;
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL cont k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
            tick();
            if (o_done) done_k.push_back(k);
        end
        checks++;
        if (done_k.size() != 3 || done_k[0] != 4 || done_k[1] != 8 || done_k[2] != 12
            || o_busy !== 1'b1 || o_done_sticky !== 1'b1) begin
            errors++;
            $display("FAIL cont_dones got n=%0d busy=%b sticky=%b exp n=3 at 4,8,12 busy=1",
                     done_k.size(), o_busy, o_done_sticky);
        end
        ce = 1'b0;
    endtask

    task automatic test_abort();
        do_reset();
        start_run(3, 2, 0, 0);
        ce = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        i_abort = 1'b1;
        #1;
        checks++;
        if (got_vec() !== exp_vec() || o_x !== 5'd2 || o_y !== 5'd1) begin
            errors++; $display("FAIL abort_pre got=%h exp=%h", got_vec(), exp_vec());
        end
        tick();
        i_abort = 1'b0;
        #1;
        checks++;
        if (got_vec() !== exp_vec() || o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++; $display("FAIL abort_post got=%h exp=%h", got_vec(), exp_vec());
        end
        // Abort coincident with the final step
        start_run(1, 0, 0, 0);
        ce = 1'b1;
        tick();
        i_abort = 1'b1;
        #1;
        checks++;
        if (got_vec() !== exp_vec() || o_last !== 1'b1) begin
            errors++; $display("FAIL abort_coll_pre got=%h exp=%h", got_vec(), exp_vec());
        end
        tick();
        i_abort = 1'b0;
        ce = 1'b0;
        #1;
        checks++;
        if (got_vec() !== exp_vec() || o_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL abort_coll got=%h exp=%h", got_vec(), exp_vec());
        end
        // Start during RUN must be ignored
        start_run(3, 3, 0, 0);
        ce = 1'b1;
        tick();
        tick();
        i_start = 1'b1;
        i_x_last = '0; i_y_last = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL start_in_run k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
            tick();
        end
        i_start = 1'b0;
        #1;
        checks++;
        if (o_x !== 5'd1 || o_y !== 5'd1 || o_busy !== 1'b1) begin
            errors++; $display("FAIL start_in_run_xy got x=%0d y=%0d exp x=1 y=1", o_x, o_y);
        end
        ce = 1'b0;
    endtask

    task automatic test_zero_limits();
        do_reset();
        start_run(0, 0, 0, 0);
        ce = 1'b1;
        #1;
        checks++;
        if (got_vec() !== exp_vec() || o_last !== 1'b1 || o_x_wrap !== 1'b1) begin
            errors++; $display("FAIL zero_pre got=%h exp=%h", got_vec(), exp_vec());
        end
        tick();
        ce = 1'b0;
        #1;
        checks++;
        if (got_vec() !== exp_vec() || o_done !== 1'b1 || o_busy !== 1'b0) begin
            errors++; $display("FAIL zero_done got=%h exp=%h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_max_limits();
        int done_at = 0;
        do_reset();
        start_run(31, 31, 31, 0);
        ce = 1'b1;
        for (int k = 1; k <= 33000 && done_at == 0; k++) begin
            #1;
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL max k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
            tick();
            if (o_done) done_at = k;
        end
        checks++;
        if (done_at != 32768 || o_x !== '0 || o_y !== '0 || o_z !== '0) begin
            errors++; $display("FAIL max_done got=%0d exp=32768", done_at);
        end
        ce = 1'b0;
    endtask

    task automatic test_no_z();
        int done_at = 0;
        bit z_bad = 0;
        do_reset();
        start_run(2, 1, 7, 0);
        ce = 1'b1;
        for (int k = 1; k <= 20 && done_at == 0; k++) begin
            #1;
            if (o_z2 !== '0) z_bad = 1;
            tick();
            if (o_done2) done_at = k;
        end
        checks++;
        if (done_at != 6 || z_bad || o_busy2 !== 1'b0) begin
            errors++; $display("FAIL no_z got done_at=%0d z_bad=%0d exp done_at=6 z_bad=0",
                               done_at, z_bad);
        end
        do_reset();
        ce = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            rst         = ($urandom_range(0, 49) == 0);
            i_start     = ($urandom_range(0, 7) == 0);
            i_abort     = ($urandom_range(0, 19) == 0);
            ce          = ($urandom_range(0, 3) != 0);
            i_mode_cont = 1'($urandom_range(0, 1));
            i_x_last    = W'($urandom_range(0, 3));
            i_y_last    = W'($urandom_range(0, 2));
            i_z_last    = W'($urandom_range(0, 2));
            #1;
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL random k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
            end
            tick();
        end
        rst = 1'b0; i_start = 1'b0; i_abort = 1'b0; ce = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot_sweep();
        test_gapped_ce();
        test_continuous();
        test_abort();
        test_zero_limits();
        test_no_z();
        test_random();
        test_max_limits();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
